// File: rtl/uc_booth.sv
// Control unit for a radix-2 Booth multiplier: sequences load, add/subtract and
// shift micro-operations on an external A/Q/M datapath for N iterations.
module uc_booth #(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic q0,
  input  logic q_1,
  output logic CargaQ,
  output logic CargaM,
  output logic ResetA,
  output logic CargaA,
  output logic Resta,
  output logic DesplazaA,
  output logic DesplazaQ,
  output logic busy,
  output logic fin
);

  localparam logic [CW-1:0] CNT_INIT = CW'(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TEST  = 3'd2,
    S_ADD   = 3'd3,
    S_SUB   = 3'd4,
    S_SHIFT = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  typedef struct packed {
    logic carga_q;
    logic carga_m;
    logic reset_a;
    logic carga_a;
    logic resta;
    logic desplaza_a;
    logic desplaza_q;
    logic busy;
    logic fin;
  } ctrl_t;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ctrl_t         ctrl_q, ctrl_d;

  // State, iteration counter and control outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        cnt_d   = CNT_INIT;
        state_d = S_TEST;
      end
      S_TEST: begin
        case ({q0, q_1})
          2'b10:   state_d = S_SUB;
          2'b01:   state_d = S_ADD;
          default: state_d = S_SHIFT;
        endcase
      end
      S_ADD:   state_d = S_SHIFT;
      S_SUB:   state_d = S_SHIFT;
      S_SHIFT: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_LAST;
        state_d = (cnt_q == CNT_LAST) ? S_DONE : S_TEST;
      end
      S_DONE:  state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore decode of the upcoming state, registered so outputs track state_q
  always_comb begin
    ctrl_d      = '0;
    ctrl_d.busy = (state_d != S_IDLE);
    case (state_d)
      S_LOAD: begin
        ctrl_d.carga_q = 1'b1;
        ctrl_d.carga_m = 1'b1;
        ctrl_d.reset_a = 1'b1;
      end
      S_ADD: begin
        ctrl_d.carga_a = 1'b1;
      end
      S_SUB: begin
        ctrl_d.carga_a = 1'b1;
        ctrl_d.resta   = 1'b1;
      end
      S_SHIFT: begin
        ctrl_d.desplaza_a = 1'b1;
        ctrl_d.desplaza_q = 1'b1;
      end
      S_DONE: begin
        ctrl_d.fin = 1'b1;
      end
      default: ;
    endcase
  end

  assign CargaQ    = ctrl_q.carga_q;
  assign CargaM    = ctrl_q.carga_m;
  assign ResetA    = ctrl_q.reset_a;
  assign CargaA    = ctrl_q.carga_a;
  assign Resta     = ctrl_q.resta;
  assign DesplazaA = ctrl_q.desplaza_a;
  assign DesplazaQ = ctrl_q.desplaza_q;
  assign busy      = ctrl_q.busy;
  assign fin       = ctrl_q.fin;

endmodule

// File: tb/tb_uc_booth.sv
// Directed bench for uc_booth driving a reference A/Q/M Booth datapath from its controls.
module tb_uc_booth;

  logic clk = 1'b0;
  logic reset, start;
  logic q0, q_1;
  logic CargaQ, CargaM, ResetA, CargaA, Resta, DesplazaA, DesplazaQ, busy, fin;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference datapath
  logic [3:0] a_r, q_r, m_r;
  logic       qm1_r;
  logic [3:0] m_in, q_in;

  always #5 clk = ~clk;

  uc_booth #(.N(4), .CW(3)) dut (
    .clk(clk), .reset(reset), .start(start), .q0(q0), .q_1(q_1),
    .CargaQ(CargaQ), .CargaM(CargaM), .ResetA(ResetA), .CargaA(CargaA),
    .Resta(Resta), .DesplazaA(DesplazaA), .DesplazaQ(DesplazaQ),
    .busy(busy), .fin(fin)
  );

  assign q0  = q_r[0];
  assign q_1 = qm1_r;

  always @(posedge clk) begin
    if (CargaM) m_r <= m_in;
    if (CargaQ) begin
      q_r   <= q_in;
      qm1_r <= 1'b0;
    end
    if (ResetA) a_r <= '0;
    if (CargaA) a_r <= Resta ? (a_r - m_r) : (a_r + m_r);
    if (DesplazaA) a_r <= {a_r[3], a_r[3:1]};
    if (DesplazaQ) begin
      q_r   <= {a_r[0], q_r[3:1]};
      qm1_r <= q_r[0];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] outs();
    return {CargaQ, CargaM, ResetA, CargaA, Resta, DesplazaA, DesplazaQ, busy, fin};
  endfunction

  // Start one operation (start sampled at the first edge, "edge 0"), follow it to fin.
  task automatic run_op(input string tag, input logic [3:0] mcand, input logic [3:0] mplier,
                        input int exp_fin, input int exp_adds, input int exp_subs,
                        input logic [7:0] exp_prod, input bit keep_start);
    int fin_at, adds, subs, shifts, excl_bad, busy_bad;
    logic [7:0] prod;
    fin_at = -1; adds = 0; subs = 0; shifts = 0; excl_bad = 0; busy_bad = 0; prod = '0;
    m_in  = mcand;
    q_in  = mplier;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!keep_start) start = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (CargaA && !Resta) adds++;
      if (Resta) subs++;
      if (DesplazaA) shifts++;
      if ((32'(CargaA) + 32'(CargaQ) + 32'(DesplazaA)) > 1) excl_bad++;
      if (!busy) busy_bad++;
      if (fin) begin
        fin_at = k;
        prod   = {a_r, q_r};
        break;
      end
    end
    check({tag, "_fin_edge"}, 32'(fin_at), 32'(exp_fin));
    check({tag, "_adds"},     32'(adds),   32'(exp_adds));
    check({tag, "_subs"},     32'(subs),   32'(exp_subs));
    check({tag, "_shifts"},   32'(shifts), 32'd4);
    check({tag, "_excl"},     32'(excl_bad), 32'd0);
    check({tag, "_busy"},     32'(busy_bad), 32'd0);
    check({tag, "_product"},  32'(prod),   32'(exp_prod));
    @(posedge clk);
    #1;
    check({tag, "_idle_after"}, 32'(outs()), 32'd0);
  endtask

  initial begin
    int subs_seen, fin_seen;
    logic hit;
    reset = 1'b0;
    start = 1'b0;
    m_in  = '0;
    q_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", 32'(outs()), 32'd0);
    start = 1'b1;
    @(posedge clk);
    #1;
    check("start_during_reset", 32'(outs()), 32'd0);
    start = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("idle_no_start", 32'(outs()), 32'd0);

    run_op("q0000", 4'b0111, 4'b0000, 9, 0, 0, 8'h00, 1'b0);
    run_op("q0101", 4'b0011, 4'b0101, 13, 2, 2, 8'h0F, 1'b0);
    run_op("q1111", 4'b0011, 4'b1111, 10, 0, 1, 8'hFD, 1'b0);
    run_op("m3x5",  4'b1101, 4'b0101, 13, 2, 2, 8'hF1, 1'b0);

    // Reset during the second SUB of -3 x 5
    m_in = 4'b1101;
    q_in = 4'b0101;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    subs_seen = 0;
    fin_seen  = 0;
    hit       = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (fin) fin_seen++;
      if (Resta) subs_seen++;
      if (subs_seen == 2) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("rst_mid_reached_sub2", 32'(hit), 32'd1);
    reset = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_outs", 32'(outs()), 32'd0);
    @(posedge clk);
    #1;
    check("rst_mid_hold_start", 32'(outs()), 32'd0);
    start = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (fin || busy) fin_seen++;
    end
    check("rst_mid_no_resume", 32'(fin_seen), 32'd0);
    run_op("after_rst", 4'b0111, 4'b1110, 10, 0, 1, 8'hF2, 1'b0);

    // start held high: back-to-back operations, one IDLE cycle between them
    run_op("b2b_1", 4'b1101, 4'b0101, 13, 2, 2, 8'hF1, 1'b1);
    run_op("b2b_2", 4'b0011, 4'b1111, 10, 0, 1, 8'hFD, 1'b1);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_stop", 32'(outs()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
